tile_c_writeback: RTL and testbench
===================================

Name: tile_c_writeback

Overview:
- Drain side of the tile datapath: the inverse of the host→SRAM→tile load path.
- Snapshots the C_tile result matrix on C_valid from tile_top.
- Serializes the snapshot row-major into a result SRAM through a single-word host-style write port, with ready backpressure.
- Lets the host read results from SRAM without sampling the wide C_tile bus.

Parameters:
- M, 8, tile rows (C_tile first index); must be ≥1.
- N, 8, tile columns (C_tile second index); must be ≥1.
- ROW_W, (M<=1)?1:$clog2(M), derived; width of cw_row.
- COL_W, (N<=1)?1:$clog2(N), derived; width of cw_col.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- C_valid  in  1  one-cycle pulse; C_tile is valid this cycle.
- C_tile  in  32 x [M][N]  FP32 result matrix (unpacked array).
- m_len  in  16  active rows; sampled with C_valid.
- n_len  in  16  active columns; sampled with C_valid.
- cw_en  out  1  write request valid.
- cw_we  out  1  write enable; equals cw_en.
- cw_row  out  ROW_W  result row index i.
- cw_col  out  COL_W  result column index j.
- cw_wdata  out  32  C[i][j].
- cw_wmask  out  4  byte mask; 4'b1111 while cw_en, else 4'b0000.
- cw_ready  in  1  SRAM accepts the write this cycle.
- busy  out  1  high from capture until the last write is accepted.
- done  out  1  one-cycle pulse after completion.
- overrun  out  1  sticky; a C_valid arrived while busy. Cleared only by reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0; state goes to IDLE.
  - Buffer contents are don't-care.
  - An in-flight drain is abandoned; no further writes after rst_n rises.
- FSM states:
  - IDLE: waits for C_valid.
  - DRAIN: issues writes.
  - FIN: drives done for one cycle, then returns to IDLE.
- Capture (IDLE, C_valid=1 at edge t):
  - All M*N words are copied into the internal buffer.
  - Effective lengths: ml=min(m_len,M), nl=min(n_len,N).
  - Row and column counters are cleared; busy=1 from t+1.
  - If ml==0 or nl==0: go to FIN directly; done at t+1, no writes issued.
  - Otherwise go to DRAIN; first cw_en=1 at t+1 with row=0, col=0.
- DRAIN:
  - cw_en=1 continuously; outputs hold stable while cw_ready=0.
  - A write is accepted on an edge where cw_en && cw_ready.
  - On accept, col increments. At col==nl-1, col wraps to 0 and row increments.
  - Accepting (row=ml-1, col=nl-1) moves to FIN: cw_en=0 and done=1 on the next cycle, busy=0 on that same cycle.
  - With cw_ready tied to 1, an ml x nl drain takes ml*nl cycles of cw_en; done appears in the cycle after the last write.
- Data:
  - cw_wdata always comes from the snapshot, never live C_tile. Later changes on C_tile do not affect the drain.
  - Words are passed bit-exactly; no FP interpretation.
- C_valid while busy (DRAIN or FIN):
  - Ignored; the snapshot is unchanged and overrun is set to 1.
- C_valid in IDLE on the same edge FIN returns:
  - FIN occupies one cycle, so C_valid in FIN counts as overrun.
- Idle values:
  - cw_row, cw_col, cw_wdata are 0 whenever cw_en=0.

Decomposition:
- Shared package tile_pkg:
  - fp32_t typedef (logic [31:0]).
  - wb_state_e enum {WB_IDLE, WB_DRAIN, WB_FIN}.
  - Constant FULL_MASK = 4'b1111.
- No sub-module is needed. The 2-D row/col counter with wrap and clamp may be a local function, or an optional sub-module tile_rc_counter (inputs ml, nl, advance; outputs row, col, last).

Test Plan:
- 8x8 full drain, cw_ready=1, C = the known diagonal-pattern result (C[0][0]=41400000, C[0][1]=41100000, C[1][0]=41340000, C[7][7]=41400000):
  - exactly 64 writes in row-major order, each data word matching;
  - done one cycle after write (7,7); busy low on done; overrun=0.
- Partial tile, m_len=6, n_len=5:
  - 30 writes; last at row=5, col=4, data C[5][4]=41100000;
  - no write with col≥5 or row≥6.
- Backpressure: cw_ready toggles 1,0,0,1 repeating during an 8x8 drain:
  - address and data held stable while stalled;
  - no duplicated or skipped (row,col); still 64 accepted writes.
- Snapshot and overrun: second C_valid with different C_tile mid-drain:
  - all writes carry the first tile's values; overrun=1 and stays 1.
- m_len=0 (n_len=8) → done at t+1, zero writes; m_len=20, n_len=3 → clamped to 8x3 = 24 writes.
- Async reset mid-drain (after 10 writes):
  - cw_en, busy, done drop immediately;
  - after release, no writes until a new C_valid, which then drains from (0,0).

Source files
------------

// File: rtl/tile_c_writeback_pkg.sv
// Shared types and constants for the tile result drain path.
package tile_pkg;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_DRAIN = 2'd1,
        WB_FIN   = 2'd2
    } wb_state_e;

    localparam logic [3:0] FULL_MASK = 4'b1111;

    // Clamp a requested length to the physical tile dimension.
    function automatic logic [15:0] clamp_len(input logic [15:0] len, input int unsigned lim);
        return (32'(len) > lim) ? 16'(lim) : len;
    endfunction

endpackage

// File: rtl/tile_c_writeback_if.sv
// Single-word result SRAM write port driven by the writeback drain.
interface tile_c_writeback_if #(
    parameter int ROW_W = 3,
    parameter int COL_W = 3
);
    import tile_pkg::*;

    logic             cw_en;
    logic             cw_we;
    logic [ROW_W-1:0] cw_row;
    logic [COL_W-1:0] cw_col;
    fp32_t            cw_wdata;
    logic [3:0]       cw_wmask;
    logic             cw_ready;

    modport master (
        output cw_en, cw_we, cw_row, cw_col, cw_wdata, cw_wmask,
        input  cw_ready
    );

    modport slave (
        input  cw_en, cw_we, cw_row, cw_col, cw_wdata, cw_wmask,
        output cw_ready
    );

endinterface

// File: rtl/tile_c_writeback_rc_counter.sv
// Row-major 2-D index counter; column wraps at col_last, row wraps after the final element.
module tile_rc_counter #(
    parameter int ROW_W = 3,
    parameter int COL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [ROW_W-1:0] row_last_i,
    input  logic [COL_W-1:0] col_last_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    assign last_o = (row_q == row_last_i) && (col_q == col_last_i);
    assign row_o  = row_q;
    assign col_o  = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == col_last_i) begin
                col_d = '0;
                row_d = last_o ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/tile_c_writeback.sv
// Snapshots the C tile on C_valid and drains it row-major into the result SRAM write port.
module tile_c_writeback
    import tile_pkg::*;
#(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int ROW_W = (M <= 1) ? 1 : $clog2(M),
    parameter int COL_W = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                C_valid,
    input  fp32_t               C_tile [M][N],
    input  logic [15:0]         m_len,
    input  logic [15:0]         n_len,
    tile_c_writeback_if.master  cw,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    if (M < 1 || N < 1) begin : g_bad_dims
        $error("tile_c_writeback: M and N must be at least 1");
    end

    localparam logic [1:0] ST_IDLE  = WB_IDLE;
    localparam logic [1:0] ST_DRAIN = WB_DRAIN;
    localparam logic [1:0] ST_FIN   = WB_FIN;

    logic [1:0]       state_q, state_d;
    logic             overrun_q, overrun_d;
    fp32_t            buf_q [M][N];
    logic [ROW_W-1:0] ml_last_q;
    logic [COL_W-1:0] nl_last_q;

    logic [15:0]      ml, nl;
    logic             capture, zero_len, accept, drain, last;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    assign ml       = clamp_len(m_len, M);
    assign nl       = clamp_len(n_len, N);
    assign zero_len = (ml == 16'd0) || (nl == 16'd0);
    assign capture  = C_valid && (state_q == ST_IDLE);
    assign drain    = (state_q == ST_DRAIN);
    assign accept   = drain && cw.cw_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (capture) state_d = zero_len ? ST_FIN : ST_DRAIN;
            ST_DRAIN: if (accept && last) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A tile arriving while a drain or its completion cycle is in progress is dropped.
    assign overrun_d = overrun_q || (C_valid && (state_q != ST_IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot storage carries no reset; it is only read while draining.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q     <= C_tile;
            ml_last_q <= ROW_W'(ml - 16'd1);
            nl_last_q <= COL_W'(nl - 16'd1);
        end
    end

    tile_rc_counter #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_rc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (capture),
        .advance_i  (accept),
        .row_last_i (ml_last_q),
        .col_last_i (nl_last_q),
        .row_o      (row),
        .col_o      (col),
        .last_o     (last)
    );

    assign cw.cw_en    = drain;
    assign cw.cw_we    = drain;
    assign cw.cw_row   = drain ? row : '0;
    assign cw.cw_col   = drain ? col : '0;
    assign cw.cw_wdata = drain ? buf_q[row][col] : '0;
    assign cw.cw_wmask = drain ? FULL_MASK : 4'b0000;

    assign busy    = drain;
    assign done    = (state_q == ST_FIN);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_tile_c_writeback.sv
// Scoreboard bench for tile_c_writeback: expected writes queued at capture, popped on accept.
module tb_tile_c_writeback;
    import tile_pkg::*;

    localparam int M = 8;
    localparam int N = 8;
    localparam int ROW_W = 3;
    localparam int COL_W = 3;

    typedef struct {
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
        fp32_t            d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        C_valid;
    fp32_t       C_tile [M][N];
    logic [15:0] m_len, n_len;
    logic        busy, done, overrun;

    tile_c_writeback_if #(.ROW_W(ROW_W), .COL_W(COL_W)) cw ();

    tile_c_writeback #(.M(M), .N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .C_valid (C_valid),
        .C_tile  (C_tile),
        .m_len   (m_len),
        .n_len   (n_len),
        .cw      (cw),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    exp_t sb_q [$];
    exp_t e;

    int   wr_cnt = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, en_rise_cyc = 0;
    logic prev_en = 1'b0, stalled = 1'b0;
    logic [31:0] held_rc, held_data, last_wr_data, last_wr_rc;
    logic bp_mode = 1'b0;
    int   bp_ph = 0;
    int   start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cw.cw_en) begin
                check("we", 32'(cw.cw_we), 32'd1);
                check("wmask", 32'(cw.cw_wmask), 32'hF);
                check("busy_drain", 32'(busy), 32'd1);
                if (!prev_en) en_rise_cyc = cyc;
                if (stalled) begin
                    check("hold_rc", 32'({cw.cw_row, cw.cw_col}), held_rc);
                    check("hold_data", cw.cw_wdata, held_data);
                end
                if (cw.cw_ready) begin
                    stalled = 1'b0;
                    if (sb_q.size() == 0) begin
                        check("sb_nonempty", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check("row", 32'(cw.cw_row), 32'(e.r));
                        check("col", 32'(cw.cw_col), 32'(e.c));
                        check("data", cw.cw_wdata, e.d);
                    end
                    wr_cnt++;
                    last_wr_cyc  = cyc;
                    last_wr_data = cw.cw_wdata;
                    last_wr_rc   = 32'({cw.cw_row, cw.cw_col});
                end else begin
                    stalled   = 1'b1;
                    held_rc   = 32'({cw.cw_row, cw.cw_col});
                    held_data = cw.cw_wdata;
                end
            end else begin
                stalled = 1'b0;
                check("idle_rc", 32'({cw.cw_row, cw.cw_col}), 32'd0);
                check("idle_data", cw.cw_wdata, 32'd0);
                check("idle_mask", 32'({cw.cw_wmask, cw.cw_we}), 32'd0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_on_done", 32'(busy), 32'd0);
            end
            prev_en = cw.cw_en;
        end
    end

    // Ready generator: tied high, or the 1,0,0,1 backpressure pattern.
    initial begin
        cw.cw_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                cw.cw_ready = (bp_ph == 0) || (bp_ph == 3);
                bp_ph = (bp_ph + 1) % 4;
            end else begin
                cw.cw_ready = 1'b1;
            end
        end
    end

    task automatic fill_tile(input int seed);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                C_tile[i][j] = 32'h3F80_0000 + 32'(seed) * 32'h0010_0000 + 32'(i * 64 + j * 4);
        if (seed == 0) begin
            C_tile[0][0] = 32'h4140_0000;
            C_tile[0][1] = 32'h4110_0000;
            C_tile[1][0] = 32'h4134_0000;
            C_tile[7][7] = 32'h4140_0000;
            C_tile[5][4] = 32'h4110_0000;
        end
    endtask

    task automatic start_tile(input int m, input int n);
        int ml = (m > M) ? M : m;
        int nl = (n > N) ? N : n;
        exp_t x;
        @(posedge clk);
        #1;
        C_valid = 1'b1;
        m_len   = 16'(m);
        n_len   = 16'(n);
        for (int i = 0; i < ml; i++)
            for (int j = 0; j < nl; j++) begin
                x.r = ROW_W'(i);
                x.c = COL_W'(j);
                x.d = C_tile[i][j];
                sb_q.push_back(x);
            end
        start_cyc = cyc;
        @(posedge clk);
        #1;
        C_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int wr_base, input int done_base,
                             input int exp_writes, input logic exp_ovr);
        int k = 0;
        while (done_cnt == done_base && k < 400) begin
            @(posedge clk);
            k++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt - done_base), 32'd1);
        check({tag, "_writes"}, 32'(wr_cnt - wr_base), 32'(exp_writes));
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        if (exp_writes > 0) begin
            check({tag, "_first_en"}, 32'(en_rise_cyc), 32'(start_cyc + 1));
            check({tag, "_done_lat"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
        end else begin
            check({tag, "_done_lat0"}, 32'(done_cyc), 32'(start_cyc + 1));
        end
        @(negedge clk);
        check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        sb_q.delete();
    endtask

    task automatic wait_writes(input int target);
        int k = 0;
        while (wr_cnt < target && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("reach_writes", 32'(wr_cnt >= target), 32'd1);
    endtask

    initial begin
        int wb, db;
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wb, db;
        rst_n   = 1'b0;
        C_valid = 1'b0;
        m_len   = 16'd0;
        n_len   = 16'd0;
        fill_tile(0);
        #2;
        check("rst_en", 32'(cw.cw_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full 8x8 drain with ready high.
        wb = wr_cnt; db = done_cnt;
        start_tile(8, 8);
        wait_done("full", wb, db, 64, 1'b0);
        check("full_last_rc", last_wr_rc, 32'({3'd7, 3'd7}));

        // Partial 6x5 tile.
        wb = wr_cnt; db = done_cnt;
        start_tile(6, 5);
        wait_done("part", wb, db, 30, 1'b0);
        check("part_last_rc", last_wr_rc, 32'({3'd5, 3'd4}));
        check("part_last_data", last_wr_data, 32'h4110_0000);

        // Backpressure 1,0,0,1.
        fill_tile(2);
        bp_ph = 0;
        bp_mode = 1'b1;
        wb = wr_cnt; db = done_cnt;
        start_tile(8, 8);
        wait_done("bp", wb, db, 64, 1'b0);
        bp_mode = 1'b0;

        // Zero rows, then clamped rows.
        fill_tile(0);
        wb = wr_cnt; db = done_cnt;
        start_tile(0, 8);
        wait_done("zero", wb, db, 0, 1'b0);
        wb = wr_cnt; db = done_cnt;
        start_tile(20, 3);
        wait_done("clamp", wb, db, 24, 1'b0);

        // Second tile mid-drain must be ignored and flagged.
        fill_tile(0);
        wb = wr_cnt; db = done_cnt;
        start_tile(8, 8);
        wait_writes(wb + 10);
        fill_tile(3);
        @(posedge clk);
        #1 C_valid = 1'b1;
        @(posedge clk);
        #1 C_valid = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        wait_done("snap", wb, db, 64, 1'b1);
        repeat (4) @(posedge clk);
        #1 check("ovr_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset mid-drain.
        fill_tile(0);
        wb = wr_cnt; db = done_cnt;
        start_tile(8, 8);
        wait_writes(wb + 10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_en", 32'(cw.cw_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wb = wr_cnt;
        repeat (6) @(posedge clk);
        #1 check("arst_no_writes", 32'(wr_cnt - wb), 32'd0);
        wb = wr_cnt; db = done_cnt;
        start_tile(8, 8);
        wait_done("post_rst", wb, db, 64, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
